// File: rtl/udcounter_193_driver.sv
// Drives the CPU/CPD/PL clock inputs of a 74xx193 counter chain with clean,
// programmable-width pulse trains and reports completion and terminal-count wrap.
module udcounter_193_driver #(
   parameter int WIDTH         = 12,
   parameter int LOW_CYCLES    = 1,
   parameter int HIGH_CYCLES   = 1,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             cp,
   input  logic             mr,
   input  logic             start,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] count,
   input  logic             abort,
   input  logic             tcu_in,
   input  logic             tcd_in,
   output logic             cpu,
   output logic             cpd,
   output logic             pl,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic [WIDTH-1:0] steps_done
);

   localparam int PW = 16;
   localparam logic [PW-1:0] LOW_LAST    = PW'(LOW_CYCLES - 1);
   localparam logic [PW-1:0] HIGH_LAST   = PW'(HIGH_CYCLES - 1);
   localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LOW, HIGH, SETTLE, DONE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] steps_q, steps_d;
   logic             dir_q, dir_d;
   logic             load_q, load_d;
   logic             abort_seen_q, abort_seen_d;
   logic             cpu_q, cpu_d;
   logic             cpd_q, cpd_d;
   logic             pl_q, pl_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wrap_q, wrap_d;

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      count_d      = count_q;
      steps_d      = steps_q;
      dir_d        = dir_q;
      load_d       = load_q;
      abort_seen_d = abort_seen_q;
      // Terminal count is only meaningful while a count clock is actually low.
      wrap_d       = wrap_q | (!cpu_q && !tcu_in) | (!cpd_q && !tcd_in);

      case (state_q)
         IDLE: begin
            if (start && !done_q) begin
               dir_d        = dir;
               load_d       = load;
               count_d      = count;
               steps_d      = '0;
               wrap_d       = 1'b0;
               abort_seen_d = 1'b0;
               phase_d      = '0;
               if (load || count != '0)
                  state_d = LOW;
               else
                  state_d = (SETTLE_CYCLES == 0) ? DONE : SETTLE;
            end
         end
         LOW: begin
            abort_seen_d = abort_seen_q | abort;
            if (phase_q == LOW_LAST) begin
               phase_d = '0;
               steps_d = steps_q + WIDTH'(1);
               state_d = HIGH;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         HIGH: begin
            abort_seen_d = abort_seen_q | abort;
            if (phase_q == HIGH_LAST) begin
               phase_d = '0;
               if (load_q || steps_q == count_q || abort_seen_d) begin
                  state_d = (SETTLE_CYCLES == 0) ? DONE : SETTLE;
               end else begin
                  state_d      = LOW;
                  abort_seen_d = 1'b0;
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         SETTLE: begin
            if (phase_q == SETTLE_LAST) begin
               phase_d = '0;
               state_d = DONE;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs follow the state one cycle later so every pin comes straight from a flop.
      cpu_d  = !(state_q == LOW && !load_q && dir_q);
      cpd_d  = !(state_q == LOW && !load_q && !dir_q);
      pl_d   = !(state_q == LOW && load_q);
      busy_d = (state_q == LOW) || (state_q == HIGH) || (state_q == SETTLE);
      done_d = (state_q == DONE);
   end

   always_ff @(posedge cp) begin
      if (!mr) begin
         state_q      <= IDLE;
         phase_q      <= '0;
         count_q      <= '0;
         steps_q      <= '0;
         dir_q        <= 1'b0;
         load_q       <= 1'b0;
         abort_seen_q <= 1'b0;
         cpu_q        <= 1'b1;
         cpd_q        <= 1'b1;
         pl_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         count_q      <= count_d;
         steps_q      <= steps_d;
         dir_q        <= dir_d;
         load_q       <= load_d;
         abort_seen_q <= abort_seen_d;
         cpu_q        <= cpu_d;
         cpd_q        <= cpd_d;
         pl_q         <= pl_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         wrap_q       <= wrap_d;
      end
   end

   assign cpu        = cpu_q;
   assign cpd        = cpd_q;
   assign pl         = pl_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign wrap       = wrap_q;
   assign steps_done = steps_q;

endmodule

// File: tb/tb_udcounter_193_driver.sv
// Bench for udcounter_193_driver: two driver instances (default timing and a
// wide/slow variant), each wired to a behavioural 12-bit 193 chain model.
module tb_udcounter_193_driver;

   localparam int LOW_B    = 2;
   localparam int HIGH_B   = 3;
   localparam int SETTLE_B = 1;

   logic        cp = 1'b0;
   logic        mr = 1'b0;
   logic        start = 1'b0;
   logic        dir = 1'b0;
   logic        load = 1'b0;
   logic        abort = 1'b0;
   logic        sel = 1'b0;
   logic [12:0] count = '0;
   logic [11:0] dChain = '0;
   logic        chainRst = 1'b0;

   logic        cpuA, cpdA, plA, busyA, doneA, wrapA;
   logic [11:0] stepsA;
   logic        cpuB, cpdB, plB, busyB, doneB, wrapB;
   logic [12:0] stepsB;
   logic [11:0] qA = '0;
   logic [11:0] qB = '0;
   logic        cpuPrevA = 1'b1, cpdPrevA = 1'b1, cpuPrevB = 1'b1, cpdPrevB = 1'b1;
   logic        tcuA, tcdA, tcuB, tcdB;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic        sel;
      logic        rstChain;
      logic        dir;
      logic        load;
      logic [12:0] count;
      logic [11:0] d;
      int          abortAt;
      int          pokeAt;
      logic [11:0] expQ;
      int          expSteps;
      logic        expWrap;
      int          expLat;
   } vec_t;

   vec_t vecs[13];

   always #5 cp = ~cp;

   udcounter_193_driver #(.WIDTH(12)) dutA (
      .cp(cp), .mr(mr), .start(start && !sel), .dir(dir), .load(load),
      .count(count[11:0]), .abort(abort && !sel), .tcu_in(tcuA), .tcd_in(tcdA),
      .cpu(cpuA), .cpd(cpdA), .pl(plA), .busy(busyA), .done(doneA),
      .wrap(wrapA), .steps_done(stepsA));

   udcounter_193_driver #(.WIDTH(13), .LOW_CYCLES(LOW_B), .HIGH_CYCLES(HIGH_B),
                          .SETTLE_CYCLES(SETTLE_B)) dutB (
      .cp(cp), .mr(mr), .start(start && sel), .dir(dir), .load(load),
      .count(count), .abort(abort && sel), .tcu_in(tcuB), .tcd_in(tcdB),
      .cpu(cpuB), .cpd(cpdB), .pl(plB), .busy(busyB), .done(doneB),
      .wrap(wrapB), .steps_done(stepsB));

   // Whole-chain behaviour: count on rising clock edges, async load while pl is low,
   // terminal-count outputs low only while the chain is at its limit and the clock is low.
   always @(cpuA, cpdA, plA, chainRst) begin
      if (chainRst) qA = '0;
      else if (!plA) qA = dChain;
      else begin
         if (cpuA === 1'b1 && cpuPrevA === 1'b0) qA = qA + 12'd1;
         if (cpdA === 1'b1 && cpdPrevA === 1'b0) qA = qA - 12'd1;
      end
      cpuPrevA = cpuA;
      cpdPrevA = cpdA;
   end

   always @(cpuB, cpdB, plB, chainRst) begin
      if (chainRst) qB = '0;
      else if (!plB) qB = dChain;
      else begin
         if (cpuB === 1'b1 && cpuPrevB === 1'b0) qB = qB + 12'd1;
         if (cpdB === 1'b1 && cpdPrevB === 1'b0) qB = qB - 12'd1;
      end
      cpuPrevB = cpuB;
      cpdPrevB = cpdB;
   end

   assign tcuA = !(qA == 12'hFFF && !cpuA);
   assign tcdA = !(qA == 12'h000 && !cpdA);
   assign tcuB = !(qB == 12'hFFF && !cpuB);
   assign tcdB = !(qB == 12'h000 && !cpdB);

   logic        cpuS, cpdS, plS, busyS, doneS, wrapS;
   logic [12:0] stepsS;
   logic [11:0] qS;

   always_comb begin
      cpuS   = sel ? cpuB  : cpuA;
      cpdS   = sel ? cpdB  : cpdA;
      plS    = sel ? plB   : plA;
      busyS  = sel ? busyB : busyA;
      doneS  = sel ? doneB : doneA;
      wrapS  = sel ? wrapB : wrapA;
      stepsS = sel ? stepsB : {1'b0, stepsA};
      qS     = sel ? qB : qA;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      int          cycles, busyCycles, misplaced, lowW, period, line;
      int          falls[3];
      int          lowCycles[3];
      logic [2:0]  prev, cur;
      lowW   = v.sel ? LOW_B : 1;
      period = v.sel ? (LOW_B + HIGH_B) : 2;
      line   = v.load ? 2 : (v.dir ? 0 : 1);
      for (int i = 0; i < 3; i++) begin
         falls[i] = 0;
         lowCycles[i] = 0;
      end
      busyCycles = 0;
      misplaced = 0;

      @(negedge cp);
      sel = v.sel; dir = v.dir; load = v.load; count = v.count; dChain = v.d;
      if (v.rstChain) begin
         chainRst = 1'b1;
         #1 chainRst = 1'b0;
      end
      start = 1'b1;
      @(negedge cp);
      start = 1'b0;
      cycles = 0;
      prev = 3'b111;
      while (!doneS && cycles < v.expLat + 50) begin
         @(negedge cp);
         cycles++;
         abort = 1'b0;
         if (v.pokeAt != 0 && cycles == v.pokeAt) begin
            start = 1'b1; dir = !v.dir; count = 13'd1;
         end else if (start) begin
            start = 1'b0; dir = v.dir; count = v.count;
         end
         cur = {plS, cpdS, cpuS};
         busyCycles += int'(busyS);
         for (int i = 0; i < 3; i++) begin
            if (!cur[i]) lowCycles[i]++;
            if (prev[i] && !cur[i]) begin
               falls[i]++;
               if (i == line && cycles != 1 + (falls[i] - 1) * period) misplaced++;
               if (i == line && v.abortAt != 0 && falls[i] == v.abortAt) abort = 1'b1;
            end
         end
         prev = cur;
      end
      abort = 1'b0;
      checkOutput($sformatf("v%0d done seen", idx), doneS, 1);
      checkOutput($sformatf("v%0d latency", idx), cycles, v.expLat);
      checkOutput($sformatf("v%0d busy cycles", idx), busyCycles, v.expLat - 1);
      checkOutput($sformatf("v%0d steps_done", idx), stepsS, v.expSteps);
      checkOutput($sformatf("v%0d wrap", idx), wrapS, v.expWrap);
      checkOutput($sformatf("v%0d chain q", idx), qS, v.expQ);
      checkOutput($sformatf("v%0d pulses", idx), falls[line], v.expSteps);
      checkOutput($sformatf("v%0d low cycles", idx), lowCycles[line], v.expSteps * lowW);
      checkOutput($sformatf("v%0d other lines", idx),
                  falls[0] + falls[1] + falls[2] - falls[line], 0);
      checkOutput($sformatf("v%0d pulse spacing", idx), misplaced, 0);
      @(negedge cp);
      checkOutput($sformatf("v%0d done one cycle", idx), doneS, 0);
   endtask

   initial begin
      int n, fallsSeen, doneSeen;
      logic prevCpu;

      // Field order: sel rstChain dir load count d abortAt pokeAt expQ expSteps expWrap expLat
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 13'd4095, 12'h000, 0, 0, 12'hFFF, 4095, 1'b0, 8193};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 13'd1,    12'h000, 0, 0, 12'h000, 1,    1'b1, 5};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 13'd0,    12'h000, 0, 0, 12'h000, 0,    1'b0, 3};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 13'd10,   12'h000, 0, 0, 12'h00A, 10,   1'b0, 23};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 13'd7,    12'h005, 0, 0, 12'h005, 1,    1'b0, 5};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 13'd6,    12'h000, 0, 0, 12'hFFF, 6,    1'b1, 15};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 13'd3,    12'h000, 0, 2, 12'h002, 3,    1'b1, 9};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 13'd10,   12'h000, 3, 0, 12'h005, 3,    1'b0, 9};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 13'd4097, 12'h000, 0, 0, 12'hFFF, 4097, 1'b1, 20487};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 13'd4,    12'h000, 0, 0, 12'h004, 4,    1'b0, 22};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 13'd10,   12'h000, 3, 0, 12'h007, 3,    1'b0, 17};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 13'd0,    12'h123, 0, 0, 12'h123, 1,    1'b0, 7};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 13'd0,    12'h000, 0, 0, 12'h123, 0,    1'b0, 2};

      repeat (3) @(negedge cp);
      checkOutput("reset cpu/cpd/pl A", {cpuA, cpdA, plA}, 3'b111);
      checkOutput("reset cpu/cpd/pl B", {cpuB, cpdB, plB}, 3'b111);
      checkOutput("reset busy/done/wrap A", {busyA, doneA, wrapA}, 3'b000);
      checkOutput("reset steps_done A", stepsA, 0);
      checkOutput("reset steps_done B", stepsB, 0);
      mr = 1'b1;
      @(negedge cp);

      for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);

      // Reset during the first of two LOW cycles on the slow instance.
      @(negedge cp);
      sel = 1'b1; dir = 1'b1; load = 1'b0; count = 13'd10;
      chainRst = 1'b1;
      #1 chainRst = 1'b0;
      start = 1'b1;
      @(negedge cp);
      start = 1'b0;
      n = 0; fallsSeen = 0; prevCpu = 1'b1;
      while (fallsSeen < 2 && n < 40) begin
         @(negedge cp);
         n++;
         if (prevCpu && !cpuB) fallsSeen++;
         prevCpu = cpuB;
      end
      checkOutput("reset test second pulse seen", fallsSeen, 2);
      mr = 1'b0;
      @(negedge cp);
      checkOutput("mid-pulse reset cpu high", cpuB, 1);
      checkOutput("mid-pulse reset busy", busyB, 0);
      checkOutput("mid-pulse reset steps_done", stepsB, 0);
      mr = 1'b1;
      fallsSeen = 0; doneSeen = 0; prevCpu = cpuB;
      repeat (30) begin
         @(negedge cp);
         if (prevCpu && !cpuB) fallsSeen++;
         if (doneB) doneSeen++;
         prevCpu = cpuB;
      end
      checkOutput("after reset no pulses", fallsSeen, 0);
      checkOutput("after reset no done", doneSeen, 0);
      checkOutput("after reset chain q", qB, 12'h002);

      // Start held through the done cycle must only be taken in the following idle cycle.
      sel = 1'b0; dir = 1'b1; load = 1'b0; count = 13'd0;
      start = 1'b1;
      @(negedge cp);
      start = 1'b0;
      n = 0;
      while (!doneA && n < 20) begin
         @(negedge cp);
         n++;
      end
      checkOutput("done-cycle test first done", n, 3);
      start = 1'b1;
      @(negedge cp);
      @(negedge cp);
      start = 1'b0;
      n = 0;
      while (!doneA && n < 20) begin
         @(negedge cp);
         n++;
      end
      checkOutput("start during done ignored", n, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/udcounter_193_driver.md
Name: udcounter_193_driver

Overview:
Synchronous initiator that drives the asynchronous count-clock inputs of a 74xx193 up/down counter chain: cpu, cpd and pl on stage 0, with tcu/tcd observed from the last stage.
- On request, it emits a train of N clean low-going count pulses in one direction, or one parallel-load pulse, with programmable pulse widths and ripple-settle time.
- It reports completion and terminal-count wrap.
- It sits between the emulated CPU's control logic and any 193-based counter chain (program counter, stack pointer).

Parameters:
WIDTH, 12, width of step-count request and steps_done counter
LOW_CYCLES, 1, cycles each count/load pulse is held low (>=1)
HIGH_CYCLES, 1, cycles the line is held high between pulses (>=1)
SETTLE_CYCLES, 2, cycles waited after the final pulse before done (>=0)

Ports:
cp  input  1  clock, all state changes on rising edge
mr  input  1  reset, synchronous, active-low
start  input  1  request; sampled only in IDLE
dir  input  1  1 = count up (pulse cpu), 0 = count down (pulse cpd); latched at start
load  input  1  1 = issue one pl pulse instead of counting; latched at start, overrides dir/count
count  input  WIDTH  number of count pulses; latched at start
abort  input  1  stop after the current pulse completes
tcu_in  input  1  terminal-count-up from last chain stage (active-low)
tcd_in  input  1  terminal-count-down from last chain stage (active-low)
cpu  output  1  up-count clock to stage 0, idles high
cpd  output  1  down-count clock to stage 0, idles high
pl  output  1  parallel load to all stages, active-low, idles high
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at completion
wrap  output  1  sticky: terminal count seen during the operation
steps_done  output  WIDTH  pulses issued in current/last operation

Behaviour:
- Reset (mr low at rising edge): state IDLE, cpu=cpd=pl=1, busy=0, done=0, wrap=0, steps_done=0, all internal counters 0. Reset takes effect mid-pulse: a low line returns high on the next cycle, and no further pulse follows.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, LOW, HIGH, SETTLE, DONE.
- IDLE:
  - If start=1, latch dir/load/count, clear wrap and steps_done, set busy.
  - Go to LOW, or to SETTLE if count==0 and load==0.
  - start while busy is ignored, with no queuing.
- LOW: the selected line (pl if load, else cpu if dir, else cpd) is held low for exactly LOW_CYCLES cycles. The other two lines stay high. Both count clocks are never low simultaneously.
- Wrap detection:
  - If in any LOW cycle (dir=1 and tcu_in=0) or (dir=0 and tcd_in=0), wrap is set next cycle.
  - tcu_in/tcd_in are ignored outside LOW and during load.
- On leaving LOW: line goes high, steps_done increments (wraps mod 2^WIDTH), go to HIGH.
- HIGH: held for HIGH_CYCLES cycles. Then go to SETTLE if any of these hold:
  - load
  - steps_done==latched count
  - abort was seen at any point since the current pulse began
  Otherwise go to LOW.
- abort in IDLE, SETTLE or DONE has no effect. Abort never shortens a LOW phase.
- SETTLE: SETTLE_CYCLES cycles, all lines high. Then go to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
  - wrap and steps_done hold until the next accepted start.
  - A start presented during the DONE cycle is ignored. Start is accepted in the following IDLE cycle.
- Latency for N>0 counted pulses, with start accepted at edge t:
  - First low edge at t+1.
  - done asserted in cycle t+1+N*(LOW_CYCLES+HIGH_CYCLES)+SETTLE_CYCLES.
  - Load behaves as N=1. count==0 gives done at t+1+SETTLE_CYCLES with no pulses.
- Pulse period is LOW_CYCLES+HIGH_CYCLES. Each count pulse produces exactly one chain increment or decrement on its rising edge.

Test Plan:
- Defaults, driver wired to three chained 193s (12-bit chain, d=0), chain reset to 0, up with count=4095 -> chain q=0xFFF, steps_done=4095, wrap=0, done 8193 cycles after start.
- Then up with count=1 -> chain q=0x000, wrap=1. Then down with count=4097 from 0 -> chain q=0xFFF, wrap=1, steps_done=4097 (WIDTH=13 for this case).
- count=0, start -> no cpu/cpd/pl low ever, done exactly 3 cycles after start edge, busy high 2 cycles.
- LOW_CYCLES=2, HIGH_CYCLES=3, count=4 up -> cpu low 2 cycles / high 3 cycles, exactly 4 pulses, cpd/pl constant 1.
- load=1, d=0x5 on chain at q=0xA, start -> pl low exactly 1 cycle, q=0x5, steps_done=1, cpu/cpd stay 1.
- Abort and reset:
  - Abort asserted during pulse 3 of count=10 -> pulse 3 completes full width, steps_done=3, done after SETTLE.
  - mr low during a LOW cycle -> line high next cycle, busy=0, no further pulses, done never asserted.
